timed_event_scheduler: RTL and testbench
========================================

TIMED_EVENT_SCHEDULER -- requirements
Module: timed_event_scheduler

Interface
REQ-001 Parameter NSLOTS, default 4, SHALL set the number of pending-event slots (legal range 2..16).
REQ-002 Parameter DW, default 16, SHALL set the width of the requested delay in clock cycles.
REQ-003 Parameter IDW, default 8, SHALL set the width of the event identifier.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 req_valid  input  1  SHALL mean a schedule request is presented.
REQ-007 req_ready  output  1  SHALL mean at least one slot is FREE and a request can be accepted this cycle.
REQ-008 req_delay  input  DW  SHALL be the delay in cycles, unsigned.
REQ-009 req_id  input  IDW  SHALL be the identifier returned when the event fires.
REQ-010 ev_valid  output  1  SHALL mean a fired event is presented.
REQ-011 ev_ready  input  1  SHALL mean the consumer takes the presented event.
REQ-012 ev_id  output  IDW  SHALL be the identifier of the presented event.
REQ-013 ev_late  output  DW  SHALL be cycles the event spent DUE before presentation, saturating at all-ones.
REQ-014 pending  output  $clog2(NSLOTS+1)  SHALL be the count of non-FREE slots.
REQ-015 now  output  32  SHALL be a free-running cycle counter that wraps from 2^32-1 to 0.

Function
REQ-016 Each slot SHALL hold state FREE, WAIT or DUE, plus remaining[DW], id[IDW] and late[DW].
REQ-017 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; req_ready SHALL depend only on registered slot state.
REQ-018 An accepted request SHALL go to the lowest-index FREE slot, loading remaining=req_delay and id=req_id.
REQ-019 Transitions: FREE->WAIT on accept when req_delay>0; FREE->DUE on accept when req_delay=0; WAIT->DUE when remaining=1; otherwise WAIT decrements remaining by 1 per cycle.
REQ-020 A request accepted at cycle T with delay d SHALL be DUE from cycle T+1+d. For d=0 that is T+1.
REQ-021 The output stage SHALL be a single register. When the output is empty, or is being emptied this cycle (ev_valid and ev_ready), it SHALL load from the lowest-index DUE slot. That slot SHALL then go DUE->FREE.
REQ-022 ev_valid, ev_id and ev_late SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-023 The earliest ev_valid for an event DUE at cycle C SHALL be cycle C+1; with ev_ready held 1, back-to-back events SHALL issue one per cycle.
REQ-024 Every DUE slot not selected in a cycle SHALL increment late, saturating.
REQ-025 A slot freed by REQ-021 in cycle T SHALL NOT be allocatable until cycle T+1.
REQ-026 A request with req_ready=0 SHALL NOT be accepted. The requester SHALL hold req_valid, req_delay and req_id stable until accepted.
REQ-027 Ties among simultaneously DUE slots SHALL resolve lowest index first; no other ordering is guaranteed.
REQ-028 pending SHALL count WAIT plus DUE slots only. The output register SHALL NOT be counted.
REQ-029 now SHALL increment by 1 every cycle outside reset.

Reset
REQ-030 When rst=1 at a rising edge, every slot SHALL become FREE and now SHALL become 0.
REQ-031 While rst=1, ev_valid=0, ev_id=0, ev_late=0, pending=0 and req_ready=0; req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted with events in WAIT, DUE or in the output register SHALL discard them all; none SHALL ever be presented.

Verification
REQ-033 Single event: accept at T with id=0x11 and delay=5, ev_ready=1 -> ev_valid=1 with ev_id=0x11 and ev_late=0 at exactly T+7 only; pending is 1 from T+1 to T+6.
REQ-034 Fill, NSLOTS=4: four accepts on consecutive cycles, delay=20 each, ids 1..4 -> req_ready=0 after the 4th accept, fifth request stalls; events fire in id order 1,2,3,4 on consecutive cycles.
REQ-035 Tie/backpressure: three requests with delay=0 accepted one per cycle, ev_ready=0 for 10 cycles then 1 -> output holds id of first request stable; later events show ev_late>0 and are delivered in slot-index order.
REQ-036 Free/alloc collision: all slots full, an event handshakes at T, new request waiting -> request accepted at T+1, not at T, into the freed slot.
REQ-037 Reset mid-operation: 3 events pending plus one presented with ev_ready=0, rst pulsed for 1 cycle -> ev_valid=0, pending=0 and now=0 after reset; no pre-reset id ever appears.
REQ-038 Wrap: force now near 2^32-1 (or run a long test) -> now wraps to 0; delays and firing are unaffected.

Source files
------------

// File: rtl/timed_event_scheduler_if.sv
// timed_event_scheduler_if: schedule-request and fired-event handshakes
interface timed_event_scheduler_if #(
   parameter int DW = 16,
   parameter int IDW = 8
);
   logic req_valid;
   logic req_ready;
   logic [DW-1:0] req_delay;
   logic [IDW-1:0] req_id;
   logic ev_valid;
   logic ev_ready;
   logic [IDW-1:0] ev_id;
   logic [DW-1:0] ev_late;
   modport master (
      output req_valid, req_delay, req_id, ev_ready,
      input  req_ready, ev_valid, ev_id, ev_late
   );
   modport slave (
      input  req_valid, req_delay, req_id, ev_ready,
      output req_ready, ev_valid, ev_id, ev_late
   );
endinterface

// File: rtl/timed_event_scheduler.sv
// timed_event_scheduler: NSLOTS countdown slots feeding a single registered event output
module timed_event_scheduler #(
   parameter int NSLOTS = 4,
   parameter int DW = 16,
   parameter int IDW = 8
) (
   input  logic clk,
   input  logic rst,
   timed_event_scheduler_if.slave bus,
   output logic [$clog2(NSLOTS+1)-1:0] pending,
   output logic [31:0] now
);
   localparam int PW = $clog2(NSLOTS+1);
   typedef enum logic [1:0] {FREE, WAIT, DUE} slot_t;
   slot_t st_q [NSLOTS];
   slot_t st_d [NSLOTS];
   logic [DW-1:0] rem_q [NSLOTS];
   logic [DW-1:0] rem_d [NSLOTS];
   logic [DW-1:0] late_q [NSLOTS];
   logic [DW-1:0] late_d [NSLOTS];
   logic [IDW-1:0] id_q [NSLOTS];
   logic [IDW-1:0] id_d [NSLOTS];
   logic [NSLOTS-1:0] alloc, take;
   logic any_free, any_due, out_load, accept;
   logic ev_valid_q, ev_valid_d;
   logic [IDW-1:0] ev_id_q, ev_id_d;
   logic [DW-1:0] ev_late_q, ev_late_d;
   logic [PW-1:0] cnt;
   // lowest-index FREE and DUE one-hots, plus occupancy count
   always_comb begin
      any_free = 1'b0;
      any_due = 1'b0;
      alloc = '0;
      take = '0;
      cnt = '0;
      for (int i = 0; i < NSLOTS; i++) begin
         alloc[i] = !any_free && st_q[i] == FREE;
         take[i] = !any_due && st_q[i] == DUE;
         any_free = any_free || st_q[i] == FREE;
         any_due = any_due || st_q[i] == DUE;
         cnt = cnt + PW'(st_q[i] != FREE);
      end
   end
   always_comb begin
      out_load = !ev_valid_q || bus.ev_ready;
      accept = bus.req_valid && bus.req_ready;
      st_d = st_q;
      rem_d = rem_q;
      id_d = id_q;
      late_d = late_q;
      ev_valid_d = out_load ? any_due : ev_valid_q;
      ev_id_d = ev_id_q;
      ev_late_d = ev_late_q;
      for (int i = 0; i < NSLOTS; i++) begin
         if (st_q[i] == WAIT) begin
            rem_d[i] = rem_q[i] - DW'(1);
            st_d[i] = rem_q[i] == DW'(1) ? DUE : WAIT;
         end
         if (st_q[i] == DUE && out_load && take[i]) begin
            st_d[i] = FREE;
            ev_id_d = id_q[i];
            ev_late_d = late_q[i];
         end else if (st_q[i] == DUE) begin
            late_d[i] = late_q[i] + DW'(late_q[i] != '1);
         end
         if (accept && alloc[i]) begin
            st_d[i] = bus.req_delay == '0 ? DUE : WAIT;
            rem_d[i] = bus.req_delay;
            id_d[i] = bus.req_id;
            late_d[i] = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= '{default: FREE};
         ev_valid_q <= 1'b0;
         ev_id_q <= '0;
         ev_late_q <= '0;
         now <= '0;
      end else begin
         st_q <= st_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q <= ev_id_d;
         ev_late_q <= ev_late_d;
         now <= now + 32'd1;
      end
   end
   // payload only matters while a slot is non-FREE, so it needs no reset
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      id_q <= id_d;
      late_q <= late_d;
   end
   assign bus.req_ready = !rst && any_free;
   assign bus.ev_valid = !rst && ev_valid_q;
   assign bus.ev_id = rst ? '0 : ev_id_q;
   assign bus.ev_late = rst ? '0 : ev_late_q;
   assign pending = rst ? '0 : cnt;
endmodule

// File: tb/tb_timed_event_scheduler.sv
// tb_timed_event_scheduler: directed scenarios with hand-computed expectations
module tb_timed_event_scheduler;
   localparam int NSLOTS = 4;
   localparam int DW = 16;
   localparam int IDW = 8;
   logic clk_generated = 1'b0;
   logic rst = 1'b1;
   logic [2:0] pending;
   logic [31:0] now;
   int tests = 0;
   int fails = 0;
   timed_event_scheduler_if #(.DW(DW), .IDW(IDW)) bus ();
   timed_event_scheduler #(.NSLOTS(NSLOTS), .DW(DW), .IDW(IDW)) dut (
      .clk(clk_generated),
      .rst(rst),
      .bus(bus.slave),
      .pending(pending),
      .now(now)
   );
   always #5 clk_generated = ~clk_generated;

   task automatic tick();
      @(posedge clk_generated);
      #1;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_delay = '0;
      bus.req_id = '0;
   endtask

   task automatic send(input logic [7:0] id, input logic [15:0] d);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_delay = d;
      bus.req_id = id;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_timeout id=%h got ready=%b want 1", id, bus.req_ready);
      end
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++;
      if (bus.ev_valid !== 1'b0 || bus.ev_id !== 8'h00 || bus.ev_late !== 16'h0) begin
         fails++;
         $display("FAIL reset_ev got valid=%b id=%h late=%h want 0/00/0000", bus.ev_valid, bus.ev_id, bus.ev_late);
      end
      tests++;
      if (bus.req_ready !== 1'b0 || pending !== 3'd0) begin
         fails++;
         $display("FAIL reset_ready_pending got ready=%b pending=%0d want 0/0", bus.req_ready, pending);
      end
      tests++;
      if (now !== 32'd0) begin
         fails++;
         $display("FAIL reset_now got %0d want 0", now);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (bus.req_ready !== 1'b1 || now !== 32'd0) begin
         fails++;
         $display("FAIL post_reset got ready=%b now=%0d want 1/0", bus.req_ready, now);
      end
      tick();
      tests++;
      if (now !== 32'd1) begin
         fails++;
         $display("FAIL now_increment got %0d want 1", now);
      end
   endtask

   task automatic test_single();
      bus.ev_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_delay = 16'd5;
      bus.req_id = 8'h11;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_ready got %b want 1", bus.req_ready);
      end
      tick();
      idle();
      for (int k = 1; k <= 9; k++) begin
         tests++;
         if (pending !== ((k <= 6) ? 3'd1 : 3'd0) || bus.ev_valid !== (k == 7)) begin
            fails++;
            $display("FAIL single_T+%0d got pending=%0d valid=%b want %0d/%b", k, pending, bus.ev_valid, (k <= 6) ? 1 : 0, k == 7);
         end
         if (k == 7) begin
            tests++;
            if (bus.ev_id !== 8'h11 || bus.ev_late !== 16'd0) begin
               fails++;
               $display("FAIL single_event got id=%h late=%0d want 11/0", bus.ev_id, bus.ev_late);
            end
         end
         tick();
      end
   endtask

   task automatic test_fill();
      logic [7:0] got[$];
      int at[$];
      int acc5 = -1;
      bus.ev_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.req_valid = 1'b1;
         bus.req_delay = 16'd20;
         bus.req_id = 8'(i);
         tests++;
         if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_ready_%0d got %b want 1", i, bus.req_ready);
         end
         tick();
      end
      bus.req_id = 8'd5;
      tests++;
      if (bus.req_ready !== 1'b0 || pending !== 3'd4) begin
         fails++;
         $display("FAIL fill_full got ready=%b pending=%0d want 0/4", bus.req_ready, pending);
      end
      for (int k = 4; k <= 45; k++) begin
         if (bus.ev_valid) begin
            got.push_back(bus.ev_id);
            at.push_back(k);
         end
         if (bus.req_valid && bus.req_ready) acc5 = k;
         tick();
         if (acc5 == k) idle();
      end
      tests++;
      if (acc5 != 22) begin
         fails++;
         $display("FAIL fill_fifth_accept got T+%0d want T+22", acc5);
      end
      tests++;
      if (got.size() != 5) begin
         fails++;
         $display("FAIL fill_count got %0d want 5", got.size());
      end
      for (int j = 0; j < 5 && j < got.size(); j++) begin
         tests++;
         if (got[j] !== 8'(j + 1) || at[j] != ((j < 4) ? 22 + j : 44)) begin
            fails++;
            $display("FAIL fill_order_%0d got id=%0d at T+%0d want id=%0d at T+%0d", j, got[j], at[j], j + 1, (j < 4) ? 22 + j : 44);
         end
      end
   endtask

   task automatic test_tie_backpressure();
      logic bad = 1'b0;
      bus.ev_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         bus.req_delay = '0;
         bus.req_id = 8'(8'h21 + i);
         tests++;
         if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL tie_ready_%0d got %b want 1", i, bus.req_ready);
         end
         tick();
      end
      idle();
      tests++;
      if (pending !== 3'd2) begin
         fails++;
         $display("FAIL tie_pending got %0d want 2", pending);
      end
      for (int k = 3; k < 12; k++) begin
         if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h21 || bus.ev_late !== 16'd0) bad = 1'b1;
         tick();
      end
      tests++;
      if (bad || bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h21) begin
         fails++;
         $display("FAIL tie_hold got valid=%b id=%h want 1/21 stable", bus.ev_valid, bus.ev_id);
      end
      bus.ev_ready = 1'b1;
      tick();
      tests++;
      if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h23 || bus.ev_late !== 16'd9) begin
         fails++;
         $display("FAIL tie_second got valid=%b id=%h late=%0d want 1/23/9", bus.ev_valid, bus.ev_id, bus.ev_late);
      end
      tick();
      tests++;
      if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h22 || bus.ev_late !== 16'd11) begin
         fails++;
         $display("FAIL tie_third got valid=%b id=%h late=%0d want 1/22/11", bus.ev_valid, bus.ev_id, bus.ev_late);
      end
      tick();
      tests++;
      if (bus.ev_valid !== 1'b0) begin
         fails++;
         $display("FAIL tie_drained got valid=%b want 0", bus.ev_valid);
      end
   endtask

   task automatic test_collision();
      logic [7:0] exp_ids [4] = '{8'h33, 8'h32, 8'h36, 8'h34};
      logic bad = 1'b0;
      bus.ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 16'd0);
      bus.req_valid = 1'b1;
      bus.req_delay = '0;
      bus.req_id = 8'h36;
      for (int k = 0; k < 3; k++) begin
         if (bus.req_ready !== 1'b0 || pending !== 3'd4) bad = 1'b1;
         tick();
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL coll_stall got ready=%b pending=%0d want 0/4", bus.req_ready, pending);
      end
      bus.ev_ready = 1'b1;
      tests++;
      if (bus.req_ready !== 1'b0 || bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h31) begin
         fails++;
         $display("FAIL coll_handshake got ready=%b valid=%b id=%h want 0/1/31", bus.req_ready, bus.ev_valid, bus.ev_id);
      end
      tick();
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL coll_freed got ready=%b want 1", bus.req_ready);
      end
      for (int j = 0; j < 4; j++) begin
         tests++;
         if (bus.ev_valid !== 1'b1 || bus.ev_id !== exp_ids[j]) begin
            fails++;
            $display("FAIL coll_order_%0d got valid=%b id=%h want 1/%h", j, bus.ev_valid, bus.ev_id, exp_ids[j]);
         end
         tick();
         if (j == 0) idle();
      end
      tests++;
      if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h35) begin
         fails++;
         $display("FAIL coll_last got valid=%b id=%h want 1/35", bus.ev_valid, bus.ev_id);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      bus.ev_ready = 1'b0;
      send(8'hA1, 16'd0);
      for (int i = 0; i < 3; i++) send(8'(8'hA2 + i), 16'd30);
      tick();
      tests++;
      if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'hA1 || pending !== 3'd3) begin
         fails++;
         $display("FAIL rmid_setup got valid=%b id=%h pending=%0d want 1/a1/3", bus.ev_valid, bus.ev_id, pending);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (bus.ev_valid !== 1'b0 || pending !== 3'd0 || bus.req_ready !== 1'b0) begin
         fails++;
         $display("FAIL rmid_during got valid=%b pending=%0d ready=%b want 0/0/0", bus.ev_valid, pending, bus.req_ready);
      end
      tick();
      rst = 1'b0;
      tests++;
      if (bus.ev_valid !== 1'b0 || pending !== 3'd0 || now !== 32'd0) begin
         fails++;
         $display("FAIL rmid_after got valid=%b pending=%0d now=%0d want 0/0/0", bus.ev_valid, pending, now);
      end
      bus.ev_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (bus.ev_valid) seen = 1'b1;
         tick();
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL rmid_discard got a pre-reset event want none");
      end
   endtask

   task automatic test_wrap();
      bus.ev_ready = 1'b1;
      force dut.now = 32'hFFFF_FFFE;
      #1;
      release dut.now;
      bus.req_valid = 1'b1;
      bus.req_delay = 16'd3;
      bus.req_id = 8'h77;
      tests++;
      if (now !== 32'hFFFF_FFFE || bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL wrap_setup got now=%h ready=%b want fffffffe/1", now, bus.req_ready);
      end
      tick();
      idle();
      tests++;
      if (now !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL wrap_max got %h want ffffffff", now);
      end
      tick();
      tests++;
      if (now !== 32'd0) begin
         fails++;
         $display("FAIL wrap_zero got %h want 0", now);
      end
      tick();
      tick();
      tests++;
      if (now !== 32'd2 || bus.ev_valid !== 1'b0) begin
         fails++;
         $display("FAIL wrap_early got now=%0d valid=%b want 2/0", now, bus.ev_valid);
      end
      tick();
      tests++;
      if (bus.ev_valid !== 1'b1 || bus.ev_id !== 8'h77 || bus.ev_late !== 16'd0) begin
         fails++;
         $display("FAIL wrap_fire got valid=%b id=%h late=%0d want 1/77/0", bus.ev_valid, bus.ev_id, bus.ev_late);
      end
      tick();
   endtask

   initial begin
      idle();
      bus.ev_ready = 1'b0;
      test_reset();
      test_single();
      test_fill();
      repeat (5) tick();
      test_tie_backpressure();
      repeat (3) tick();
      test_collision();
      repeat (3) tick();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
